// File: rtl/range_comparator_hyst_if.sv
// ----------------------------------------------------------------------------
// range_comparator_hyst_if
//
// Purpose:
//   Bundles the sample stream and the classification stream of the range
//   comparator into one interface. The producer and consumer side of the
//   comparator both live here, so a single connection carries the whole
//   handshake.
//
// Parameters:
//   WIDTH      bit width of num, lo and hi
//
// Signals:
//   num        sample value                         (producer -> comparator)
//   lo, hi     run-time thresholds                  (producer -> comparator)
//   in_valid   num is valid                         (producer -> comparator)
//   in_ready   comparator can take num              (comparator -> producer)
//   out        one-hot class {below, within, above} (comparator -> consumer)
//   out_valid  out holds an unconsumed result       (comparator -> consumer)
//   out_ready  consumer takes out                   (consumer -> comparator)
//   cfg_err    last accepted sample had lo > hi     (comparator -> consumer)
//
// Modports:
//   master     environment view (drives samples, thresholds and out_ready)
//   slave      comparator view
// ----------------------------------------------------------------------------
interface range_comparator_hyst_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] num;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       out;
  logic             out_valid;
  logic             out_ready;
  logic             cfg_err;

  modport master (
    output num,
    output lo,
    output hi,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out,
    input  out_valid,
    input  cfg_err
  );

  modport slave (
    input  num,
    input  lo,
    input  hi,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out,
    output out_valid,
    output cfg_err
  );
endinterface

// File: rtl/range_comparator_hyst.sv
// ----------------------------------------------------------------------------
// range_comparator_hyst
//
// Purpose:
//   Streaming window comparator with hysteresis. Every accepted sample is
//   classified against the thresholds lo/hi as below, within or above and
//   the result is presented one cycle later as a one-hot code together with
//   out_valid. The previous class is remembered so that leaving the below
//   or above region requires crossing the threshold by HYST extra LSBs,
//   which suppresses chatter from noisy samples sitting on a threshold.
//
// Parameters:
//   WIDTH   bit width of num, lo and hi
//   HYST    hysteresis margin in LSBs (0 gives a plain comparator),
//           allowed range 0 .. 2**WIDTH
//   CNT_W   width of each statistics counter (only with STATS_EN)
//
// Ports:
//   clk_i         rising-edge clock
//   rst_i         synchronous active-high reset
//   cmp           range_comparator_hyst_if.slave, the sample / result stream
//   cnt_clr_i     synchronous clear of all counters   (STATS_EN only)
//   cnt_below_o   accepted results classified below   (STATS_EN only)
//   cnt_within_o  accepted results classified within  (STATS_EN only)
//   cnt_above_o   accepted results classified above   (STATS_EN only)
//
// Configuration macro:
//   STATS_EN  when defined, adds the saturating per-class result counters
//             and their ports. Without it the comparator is otherwise
//             identical.
// ----------------------------------------------------------------------------
module range_comparator_hyst #(
  parameter int WIDTH = 4,
  parameter int HYST  = 1,
  parameter int CNT_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
`ifdef STATS_EN
  input  logic                   cnt_clr_i,
  output logic [CNT_W-1:0]       cnt_below_o,
  output logic [CNT_W-1:0]       cnt_within_o,
  output logic [CNT_W-1:0]       cnt_above_o,
`endif
  range_comparator_hyst_if.slave cmp
);

  // Two extra bits give a sign bit plus headroom, so lo+HYST and hi-HYST
  // can neither wrap past the top nor turn a small hi into a huge number.
  localparam int EXT_W = WIDTH + 2;
  localparam logic signed [EXT_W-1:0] HYST_S = EXT_W'(HYST);

  // Parameter sanity checks at elaboration.
  generate
    if (WIDTH < 1) begin : gBadWidth
      $error("range_comparator_hyst: WIDTH must be at least 1");
    end
    if (HYST < 0 || HYST > (2 ** WIDTH)) begin : gBadHyst
      $error("range_comparator_hyst: HYST must lie in 0 .. 2**WIDTH");
    end
    if (CNT_W < 1) begin : gBadCntW
      $error("range_comparator_hyst: CNT_W must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_NONE,
    ST_BELOW,
    ST_WITHIN,
    ST_ABOVE
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] out_q, out_d;
  logic       outValid_q, outValid_d;
  logic       cfgErr_q, cfgErr_d;

  logic                    inReady;
  logic                    accept;
  logic                    cfgBad;
  logic signed [EXT_W-1:0] numExt, loExt, hiExt;
  logic signed [EXT_W-1:0] loEff, hiEff;
  logic                    isBelow, isWithin, isAbove;

  // Handshake: a new sample can enter whenever the output slot is empty or
  // is being drained in this very cycle, which gives full throughput.
  assign inReady = !outValid_q || cmp.out_ready;
  assign accept  = cmp.in_valid && inReady;

  // Thresholds crossed the wrong way round: no class can be given.
  assign cfgBad = (cmp.lo > cmp.hi);

  // Zero-extend into the signed working width before adding the margin.
  assign numExt = signed'({2'b00, cmp.num});
  assign loExt  = signed'({2'b00, cmp.lo});
  assign hiExt  = signed'({2'b00, cmp.hi});

  // The margin only applies to the side we are currently sitting on; from
  // NONE or WITHIN the plain thresholds are used.
  assign loEff = (state_q == ST_BELOW) ? (loExt + HYST_S) : loExt;
  assign hiEff = (state_q == ST_ABOVE) ? (hiExt - HYST_S) : hiExt;

  // With a large margin the widened ranges can overlap; below is tested
  // first so it wins, and the three flags stay mutually exclusive.
  assign isBelow  = (numExt < loEff);
  assign isAbove  = !isBelow && (numExt > hiEff);
  assign isWithin = !isBelow && !isAbove;

  // State and result registers. Reset drops any result still waiting to be
  // consumed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_NONE;
      out_q      <= 3'b000;
      outValid_q <= 1'b0;
      cfgErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      outValid_q <= outValid_d;
      cfgErr_q   <= cfgErr_d;
    end
  end

  // Next-state and result logic. Everything holds unless a sample is
  // accepted; a consume without a new sample only clears out_valid and
  // leaves the last class visible on out.
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    outValid_d = outValid_q;
    cfgErr_d   = cfgErr_q;

    if (accept) begin
      outValid_d = 1'b1;
      if (cfgBad) begin
        out_d    = 3'b000;
        cfgErr_d = 1'b1;
        state_d  = ST_NONE;
      end else begin
        out_d    = {isBelow, isWithin, isAbove};
        cfgErr_d = 1'b0;
        if (isBelow) begin
          state_d = ST_BELOW;
        end else if (isAbove) begin
          state_d = ST_ABOVE;
        end else begin
          state_d = ST_WITHIN;
        end
      end
    end else if (outValid_q && cmp.out_ready) begin
      outValid_d = 1'b0;
    end
  end

  assign cmp.in_ready  = inReady;
  assign cmp.out       = out_q;
  assign cmp.out_valid = outValid_q;
  assign cmp.cfg_err   = cfgErr_q;

`ifdef STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cntBelow_q, cntBelow_d;
  logic [CNT_W-1:0] cntWithin_q, cntWithin_d;
  logic [CNT_W-1:0] cntAbove_q, cntAbove_d;
  logic             countable;

  // Only real classifications are counted; a crossed-threshold sample
  // produces no class and therefore no count.
  assign countable = accept && !cfgBad;

  // Counter registers, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cntBelow_q  <= '0;
      cntWithin_q <= '0;
      cntAbove_q  <= '0;
    end else begin
      cntBelow_q  <= cntBelow_d;
      cntWithin_q <= cntWithin_d;
      cntAbove_q  <= cntAbove_d;
    end
  end

  // Saturating increments on the same edge the result lands. A clear
  // request overrides an increment arriving in the same cycle.
  always_comb begin
    cntBelow_d  = cntBelow_q;
    cntWithin_d = cntWithin_q;
    cntAbove_d  = cntAbove_q;

    if (cnt_clr_i) begin
      cntBelow_d  = '0;
      cntWithin_d = '0;
      cntAbove_d  = '0;
    end else if (countable) begin
      if (isBelow && (cntBelow_q != CNT_MAX)) begin
        cntBelow_d = cntBelow_q + 1'b1;
      end
      if (isWithin && (cntWithin_q != CNT_MAX)) begin
        cntWithin_d = cntWithin_q + 1'b1;
      end
      if (isAbove && (cntAbove_q != CNT_MAX)) begin
        cntAbove_d = cntAbove_q + 1'b1;
      end
    end
  end

  assign cnt_below_o  = cntBelow_q;
  assign cnt_within_o = cntWithin_q;
  assign cnt_above_o  = cntAbove_q;
`endif

endmodule
